// File: rtl/p4_router_dequeue_scheduler.sv
// rtl/p4_router_dequeue_scheduler.sv - egress dequeue engine: queue arbitration, head-pointer lookup, buffer read and occupancy decrement
// Build option: define P4_ROUTER_DEQ_STRICT_PRIO_EN for strict-priority arbitration instead of round-robin.
module p4_router_dequeue_scheduler #(
    parameter int NUM_EGR_PORTS           = 4,
    parameter int NUM_QUEUES_PER_EGR_PORT = 8,
    parameter int NUM_QUEUES              = NUM_EGR_PORTS * NUM_QUEUES_PER_EGR_PORT,
    parameter int NUM_PAGES               = 256,
    parameter int WORDS_PER_PAGE          = 64,
    parameter int BYTES_PER_WORD          = 64,
    parameter int RSP_TIMEOUT             = 16
) (
    input  logic                                                 clk_i,
    input  logic                                                 areset_i,
    input  logic [NUM_QUEUES-1:0]                                queue_empty_i,
    input  logic [NUM_EGR_PORTS-1:0]                             egr_ready_i,
    output logic                                                 hp_arvalid_o,
    output logic [$clog2(NUM_QUEUES)-1:0]                        hp_araddr_o,
    input  logic                                                 hp_arready_i,
    input  logic                                                 hp_rvalid_i,
    input  logic [$clog2(NUM_PAGES)-1:0]                         hp_rdata_page_i,
    input  logic [$clog2(WORDS_PER_PAGE)-1:0]                    hp_rdata_word_i,
    output logic                                                 hp_rready_o,
    output logic                                                 buf_rd_valid_o,
    output logic [$clog2(NUM_PAGES)+$clog2(WORDS_PER_PAGE)-1:0]  buf_rd_addr_o,
    output logic [$clog2(NUM_QUEUES)-1:0]                        buf_rd_queue_o,
    output logic                                                 deq_occ_tvalid_o,
    output logic [15:0]                                          deq_occ_tdata_o,
    output logic [$clog2(NUM_QUEUES)-1:0]                        deq_occ_tuser_o,
    output logic                                                 rsp_timeout_err_o
);

    localparam int QW = $clog2(NUM_QUEUES);
    localparam int PW = $clog2(NUM_PAGES);
    localparam int WW = $clog2(WORDS_PER_PAGE);
    localparam int CW = $clog2(RSP_TIMEOUT + 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_ISSUE = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [QW-1:0]         qsel_q, qsel_d;
    logic                  arvalid_q, arvalid_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  buf_rd_valid_q, buf_rd_valid_d;
    logic [PW+WW-1:0]      buf_rd_addr_q, buf_rd_addr_d;
    logic [QW-1:0]         buf_rd_queue_q, buf_rd_queue_d;
    logic                  occ_tvalid_q, occ_tvalid_d;
    logic [15:0]           occ_tdata_q, occ_tdata_d;
    logic [QW-1:0]         occ_tuser_q, occ_tuser_d;
    logic                  err_q, err_d;

    logic [NUM_QUEUES-1:0] eligible;
    logic                  any_eligible;
    logic [QW-1:0]         winner;

    // A queue competes only while it holds data and its egress port has room.
    for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_elig
        assign eligible[g] = ~queue_empty_i[g] & egr_ready_i[g / NUM_QUEUES_PER_EGR_PORT];
    end

`ifdef P4_ROUTER_DEQ_STRICT_PRIO_EN
    always_comb begin
        winner       = '0;
        any_eligible = 1'b0;
        for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
            if (eligible[QW'(i)]) begin
                winner       = QW'(i);
                any_eligible = 1'b1;
            end
        end
    end
`else
    logic [QW-1:0] rr_q, rr_d;
    logic [QW-1:0] cand;

    // Search begins one past the last winner and wraps, so the last winner ranks lowest.
    always_comb begin
        winner       = '0;
        any_eligible = 1'b0;
        cand         = '0;
        for (int i = 1; i <= NUM_QUEUES; i++) begin
            cand = QW'((int'(rr_q) + i) % NUM_QUEUES);
            if (!any_eligible && eligible[cand]) begin
                winner       = cand;
                any_eligible = 1'b1;
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (state_q == ST_IDLE && any_eligible) begin
            rr_d = winner;
        end
    end

    always_ff @(posedge clk_i or posedge areset_i) begin
        if (areset_i) begin
            rr_q <= QW'(NUM_QUEUES - 1);
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    always_comb begin
        state_d        = state_q;
        qsel_d         = qsel_q;
        arvalid_d      = arvalid_q;
        cnt_d          = cnt_q;
        buf_rd_valid_d = 1'b0;
        buf_rd_addr_d  = buf_rd_addr_q;
        buf_rd_queue_d = buf_rd_queue_q;
        occ_tvalid_d   = 1'b0;
        occ_tdata_d    = occ_tdata_q;
        occ_tuser_d    = occ_tuser_q;
        err_d          = err_q;
        case (state_q)
            ST_IDLE: begin
                if (any_eligible) begin
                    qsel_d    = winner;
                    arvalid_d = 1'b1;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (hp_arready_i) begin
                    arvalid_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Strobes are registered on the way into ISSUE so they are high for exactly that cycle.
                if (hp_rvalid_i) begin
                    buf_rd_valid_d = 1'b1;
                    buf_rd_addr_d  = {hp_rdata_page_i, hp_rdata_word_i};
                    buf_rd_queue_d = qsel_q;
                    occ_tvalid_d   = 1'b1;
                    occ_tdata_d    = 16'(BYTES_PER_WORD);
                    occ_tuser_d    = qsel_q;
                    state_d        = ST_ISSUE;
                end else if (cnt_q == CW'(RSP_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_ISSUE: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge areset_i) begin
        if (areset_i) begin
            state_q        <= ST_IDLE;
            qsel_q         <= '0;
            arvalid_q      <= 1'b0;
            cnt_q          <= '0;
            buf_rd_valid_q <= 1'b0;
            buf_rd_addr_q  <= '0;
            buf_rd_queue_q <= '0;
            occ_tvalid_q   <= 1'b0;
            occ_tdata_q    <= '0;
            occ_tuser_q    <= '0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            qsel_q         <= qsel_d;
            arvalid_q      <= arvalid_d;
            cnt_q          <= cnt_d;
            buf_rd_valid_q <= buf_rd_valid_d;
            buf_rd_addr_q  <= buf_rd_addr_d;
            buf_rd_queue_q <= buf_rd_queue_d;
            occ_tvalid_q   <= occ_tvalid_d;
            occ_tdata_q    <= occ_tdata_d;
            occ_tuser_q    <= occ_tuser_d;
            err_q          <= err_d;
        end
    end

    assign hp_arvalid_o      = arvalid_q;
    assign hp_araddr_o       = qsel_q;
    assign hp_rready_o       = 1'b1;
    assign buf_rd_valid_o    = buf_rd_valid_q;
    assign buf_rd_addr_o     = buf_rd_addr_q;
    assign buf_rd_queue_o    = buf_rd_queue_q;
    assign deq_occ_tvalid_o  = occ_tvalid_q;
    assign deq_occ_tdata_o   = occ_tdata_q;
    assign deq_occ_tuser_o   = occ_tuser_q;
    assign rsp_timeout_err_o = err_q;

endmodule

// File: tb/tb_p4_router_dequeue_scheduler.sv
// tb/tb_p4_router_dequeue_scheduler.sv - randomized self-checking bench for the dequeue scheduler
module tb_p4_router_dequeue_scheduler;
    localparam int NQ = 32, NP = 4, NQPP = 8, QW = 5, PW = 8, WW = 6;
    localparam int WPP = 64, BPW = 64, TMO = 16;

    logic clk = 1'b0;
    logic areset;
    logic [NQ-1:0] queue_empty;
    logic [NP-1:0] egr_ready;
    logic hp_arready, hp_rvalid;
    logic [PW-1:0] hp_rdata_page;
    logic [WW-1:0] hp_rdata_word;
    logic hp_arvalid, hp_rready, buf_rd_valid, deq_occ_tvalid, rsp_timeout_err;
    logic [QW-1:0] hp_araddr, buf_rd_queue, deq_occ_tuser;
    logic [PW+WW-1:0] buf_rd_addr;
    logic [15:0] deq_occ_tdata;

    int tests_run = 0, tests_failed = 0;
    int rr_m = NQ - 1;
    int n_buf = 0, n_occ = 0, n_pair_err = 0;
    int last_addr = 0, last_bq = 0, last_tdata = 0, last_tuser = 0;

    always #5 clk = ~clk;

    p4_router_dequeue_scheduler dut (
        .clk_i(clk), .areset_i(areset), .queue_empty_i(queue_empty), .egr_ready_i(egr_ready),
        .hp_arvalid_o(hp_arvalid), .hp_araddr_o(hp_araddr), .hp_arready_i(hp_arready),
        .hp_rvalid_i(hp_rvalid), .hp_rdata_page_i(hp_rdata_page), .hp_rdata_word_i(hp_rdata_word),
        .hp_rready_o(hp_rready), .buf_rd_valid_o(buf_rd_valid), .buf_rd_addr_o(buf_rd_addr),
        .buf_rd_queue_o(buf_rd_queue), .deq_occ_tvalid_o(deq_occ_tvalid), .deq_occ_tdata_o(deq_occ_tdata),
        .deq_occ_tuser_o(deq_occ_tuser), .rsp_timeout_err_o(rsp_timeout_err)
    );

    always @(negedge clk) begin
        if (!areset) begin
            if (buf_rd_valid === 1'b1) begin
                n_buf     <= n_buf + 1;
                last_addr <= int'(buf_rd_addr);
                last_bq   <= int'(buf_rd_queue);
            end
            if (deq_occ_tvalid === 1'b1) begin
                n_occ      <= n_occ + 1;
                last_tdata <= int'(deq_occ_tdata);
                last_tuser <= int'(deq_occ_tuser);
            end
            if (buf_rd_valid !== deq_occ_tvalid) n_pair_err <= n_pair_err + 1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [NQ-1:0] cur_elig();
        logic [NQ-1:0] e;
        for (int q = 0; q < NQ; q++) e[q] = !queue_empty[q] && egr_ready[q / NQPP];
        return e;
    endfunction

    // Expected winner from the arbitration rule, given the current eligible set.
    function automatic int predict(input logic [NQ-1:0] elig);
`ifdef P4_ROUTER_DEQ_STRICT_PRIO_EN
        for (int i = 0; i < NQ; i++) if (elig[i]) return i;
`else
        for (int i = 1; i <= NQ; i++) if (elig[(rr_m + i) % NQ]) return (rr_m + i) % NQ;
`endif
        return -1;
    endfunction

    task automatic apply_reset();
        areset = 1'b1; queue_empty = '1; egr_ready = '1;
        hp_arready = 1'b0; hp_rvalid = 1'b0; hp_rdata_page = '0; hp_rdata_word = '0;
        repeat (2) @(negedge clk);
        areset = 1'b0; rr_m = NQ - 1;
    endtask

    // Plays the queue-state store for one lookup; returns the requested queue and whether the request held steady.
    task automatic run_txn(input int ar_dly, input int rsp_dly, input logic [PW-1:0] pg, input logic [WW-1:0] wd,
                           input bit drop, output int q, output bit stable, output bit got);
        int guard;
        logic [QW-1:0] a0;
        got = 1'b0; stable = 1'b1; q = -1; guard = 0;
        while (hp_arvalid !== 1'b1 && guard < 40) begin @(negedge clk); guard++; end
        if (hp_arvalid !== 1'b1) return;
        q = int'(hp_araddr); a0 = hp_araddr;
        if (drop) begin egr_ready = '0; queue_empty = '1; end
        for (int i = 0; i < ar_dly; i++) begin
            @(negedge clk);
            if (hp_arvalid !== 1'b1 || hp_araddr !== a0) stable = 1'b0;
        end
        hp_arready = 1'b1; @(negedge clk); hp_arready = 1'b0;
        if (hp_arvalid !== 1'b0) stable = 1'b0;
        for (int i = 0; i < rsp_dly; i++) @(negedge clk);
        hp_rvalid = 1'b1; hp_rdata_page = pg; hp_rdata_word = wd;
        @(negedge clk);
        hp_rvalid = 1'b0;
        @(negedge clk);
        got = 1'b1;
    endtask

    task automatic test_reset();
        areset = 1'b1; queue_empty = '0; egr_ready = '1;
        hp_arready = 1'b0; hp_rvalid = 1'b0; hp_rdata_page = '0; hp_rdata_word = '0;
        repeat (3) @(negedge clk);
        tests_run++; if ({hp_arvalid, buf_rd_valid, deq_occ_tvalid, rsp_timeout_err} !== 4'b0) begin tests_failed++; $display("FAIL reset_strobes: got %b want 0000", {hp_arvalid, buf_rd_valid, deq_occ_tvalid, rsp_timeout_err}); end
        tests_run++; if (hp_araddr !== '0 || buf_rd_queue !== '0 || deq_occ_tuser !== '0) begin tests_failed++; $display("FAIL reset_ids: got %0d/%0d/%0d want 0/0/0", hp_araddr, buf_rd_queue, deq_occ_tuser); end
        tests_run++; if (buf_rd_addr !== '0 || deq_occ_tdata !== '0) begin tests_failed++; $display("FAIL reset_data: got %0h/%0h want 0/0", buf_rd_addr, deq_occ_tdata); end
        tests_run++; if (hp_rready !== 1'b1) begin tests_failed++; $display("FAIL reset_rready: got %b want 1", hp_rready); end
        queue_empty = '1; areset = 1'b0; rr_m = NQ - 1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int q, q_exp, b0, o0; bit st, got;
        queue_empty = '1; queue_empty[5] = 1'b0; egr_ready = '1;
        q_exp = predict(cur_elig()); b0 = n_buf; o0 = n_occ;
        run_txn(0, 0, 8'h12, 6'h07, 1'b0, q, st, got);
        rr_m = q_exp; queue_empty = '1;
        repeat (4) @(negedge clk);
        tests_run++; if (q !== 5 || q_exp !== 5) begin tests_failed++; $display("FAIL single_araddr: got %0d want 5", q); end
        tests_run++; if (n_buf - b0 !== 1 || n_occ - o0 !== 1) begin tests_failed++; $display("FAIL single_strobes: got %0d/%0d want 1/1", n_buf - b0, n_occ - o0); end
        tests_run++; if (last_addr !== 'h12 * WPP + 'h07) begin tests_failed++; $display("FAIL single_addr: got %0h want 487", last_addr); end
        tests_run++; if (last_bq !== 5 || last_tuser !== 5 || last_tdata !== BPW) begin tests_failed++; $display("FAIL single_occ: got q%0d tuser%0d tdata%0d want 5/5/%0d", last_bq, last_tuser, last_tdata, BPW); end
    endtask

    task automatic test_round_robin();
        int q, q_exp, b0; bit st, got;
        apply_reset();
        queue_empty = '1; queue_empty[0] = 1'b0; queue_empty[3] = 1'b0; queue_empty[9] = 1'b0;
        b0 = n_buf;
        for (int k = 0; k < 5; k++) begin
            q_exp = predict(cur_elig());
            run_txn(0, 0, PW'(k), WW'(k), 1'b0, q, st, got);
            tests_run++; if (q !== q_exp) begin tests_failed++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, q, q_exp); end
            rr_m = q_exp;
        end
        queue_empty = '1;
        @(negedge clk);
        tests_run++; if (n_buf - b0 !== 5) begin tests_failed++; $display("FAIL rr_count: got %0d want 5", n_buf - b0); end
    endtask

    task automatic test_egr_gating();
        int q, q_exp; bit st, got, seen;
        queue_empty = '1; queue_empty[10] = 1'b0; egr_ready = 4'b1101; seen = 1'b0;
        repeat (8) begin @(negedge clk); if (hp_arvalid !== 1'b0) seen = 1'b1; end
        tests_run++; if (seen !== 1'b0) begin tests_failed++; $display("FAIL egr_blocked: got request want none"); end
        egr_ready = '1; q_exp = predict(cur_elig());
        @(negedge clk);
        tests_run++; if (hp_arvalid !== 1'b1 || int'(hp_araddr) !== q_exp) begin tests_failed++; $display("FAIL egr_release: got v%b q%0d want v1 q%0d", hp_arvalid, hp_araddr, q_exp); end
        run_txn(0, 0, 8'h01, 6'h02, 1'b0, q, st, got);
        rr_m = q_exp; queue_empty = '1;
        tests_run++; if (q !== q_exp || last_bq !== q_exp) begin tests_failed++; $display("FAIL egr_txn: got %0d/%0d want %0d", q, last_bq, q_exp); end
    endtask

    task automatic test_arready_stall();
        int q, q_exp, b0; bit st, got;
        queue_empty = '1; queue_empty[20] = 1'b0; egr_ready = '1;
        q_exp = predict(cur_elig()); b0 = n_buf;
        run_txn(3, 0, 8'hA5, 6'h3C, 1'b1, q, st, got);
        rr_m = q_exp; egr_ready = '1; queue_empty = '1;
        @(negedge clk);
        tests_run++; if (st !== 1'b1) begin tests_failed++; $display("FAIL stall_stable: got %b want 1", st); end
        tests_run++; if (q !== q_exp || n_buf - b0 !== 1 || last_bq !== q_exp) begin tests_failed++; $display("FAIL stall_txn: got q%0d n%0d bq%0d want q%0d n1", q, n_buf - b0, last_bq, q_exp); end
        tests_run++; if (last_addr !== 'hA5 * WPP + 'h3C) begin tests_failed++; $display("FAIL stall_addr: got %0h want %0h", last_addr, 'hA5 * WPP + 'h3C); end
    endtask

    task automatic test_timeout();
        int q, q_exp, b0, o0, guard, waited; bit st, got;
        queue_empty = '1; queue_empty[7] = 1'b0; queue_empty[12] = 1'b0; egr_ready = '1;
        q_exp = predict(cur_elig()); b0 = n_buf; o0 = n_occ; guard = 0;
        while (hp_arvalid !== 1'b1 && guard < 40) begin @(negedge clk); guard++; end
        tests_run++; if (hp_arvalid !== 1'b1 || int'(hp_araddr) !== q_exp) begin tests_failed++; $display("FAIL tmo_req: got v%b q%0d want v1 q%0d", hp_arvalid, hp_araddr, q_exp); end
        rr_m = q_exp;
        hp_arready = 1'b1; @(negedge clk); hp_arready = 1'b0;
        waited = 0;
        while (rsp_timeout_err !== 1'b1 && waited < 40) begin @(negedge clk); waited++; end
        tests_run++; if (rsp_timeout_err !== 1'b1 || waited < TMO || waited > TMO + 1) begin tests_failed++; $display("FAIL tmo_flag: got err%b after %0d cycles want 1 after %0d", rsp_timeout_err, waited, TMO); end
        tests_run++; if (n_buf !== b0 || n_occ !== o0) begin tests_failed++; $display("FAIL tmo_nostrobe: got %0d/%0d want 0/0", n_buf - b0, n_occ - o0); end
        hp_rvalid = 1'b1; hp_rdata_page = 8'hFF; hp_rdata_word = 6'h3F;
        @(negedge clk);
        hp_rvalid = 1'b0;
        q_exp = predict(cur_elig()); b0 = n_buf;
        run_txn(0, 1, 8'h33, 6'h11, 1'b0, q, st, got);
        rr_m = q_exp; queue_empty = '1;
        tests_run++; if (q !== q_exp || n_buf - b0 !== 1 || last_addr !== 'h33 * WPP + 'h11) begin tests_failed++; $display("FAIL tmo_next: got q%0d n%0d a%0h want q%0d n1", q, n_buf - b0, last_addr, q_exp); end
        tests_run++; if (rsp_timeout_err !== 1'b1) begin tests_failed++; $display("FAIL tmo_sticky: got %b want 1", rsp_timeout_err); end
    endtask

    task automatic test_reset_in_wait();
        int guard, b0, o0;
        queue_empty = '1; queue_empty[4] = 1'b0; egr_ready = '1; guard = 0;
        while (hp_arvalid !== 1'b1 && guard < 40) begin @(negedge clk); guard++; end
        tests_run++; if (hp_arvalid !== 1'b1 || hp_araddr !== 5'd4) begin tests_failed++; $display("FAIL rstw_req: got v%b q%0d want v1 q4", hp_arvalid, hp_araddr); end
        hp_arready = 1'b1; @(negedge clk); hp_arready = 1'b0;
        @(negedge clk);
        areset = 1'b1;
        #1;
        tests_run++; if ({hp_arvalid, buf_rd_valid, deq_occ_tvalid, rsp_timeout_err} !== 4'b0) begin tests_failed++; $display("FAIL rstw_flags: got %b want 0000", {hp_arvalid, buf_rd_valid, deq_occ_tvalid, rsp_timeout_err}); end
        tests_run++; if (hp_araddr !== '0 || buf_rd_queue !== '0 || deq_occ_tuser !== '0 || buf_rd_addr !== '0 || deq_occ_tdata !== '0) begin tests_failed++; $display("FAIL rstw_values: got %0d/%0d/%0d/%0h/%0d want all 0", hp_araddr, buf_rd_queue, deq_occ_tuser, buf_rd_addr, deq_occ_tdata); end
        hp_rvalid = 1'b1; queue_empty = '1;
        @(negedge clk);
        hp_rvalid = 1'b0;
        @(negedge clk);
        areset = 1'b0; rr_m = NQ - 1; b0 = n_buf; o0 = n_occ;
        repeat (10) @(negedge clk);
        tests_run++; if (n_buf !== b0 || n_occ !== o0) begin tests_failed++; $display("FAIL rstw_nostrobe: got %0d/%0d want 0/0", n_buf - b0, n_occ - o0); end
    endtask

    task automatic test_random();
        int words[NQ];
        int q, q_exp, b0, o0, k;
        bit st, got;
        logic [PW-1:0] pg;
        logic [WW-1:0] wd;
        for (int i = 0; i < NQ; i++) words[i] = $urandom_range(0, 3);
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < NQ; i++) queue_empty[i] = (words[i] == 0);
            egr_ready = NP'($urandom);
            if (cur_elig() == '0) begin
                egr_ready = '1;
                if (cur_elig() == '0) begin k = $urandom_range(0, NQ - 1); words[k] = 2; queue_empty[k] = 1'b0; end
            end
            q_exp = predict(cur_elig());
            pg = PW'($urandom); wd = WW'($urandom); b0 = n_buf; o0 = n_occ;
            run_txn($urandom_range(0, 3), $urandom_range(0, 5), pg, wd, 1'b0, q, st, got);
            tests_run++; if (q !== q_exp) begin tests_failed++; $display("FAIL rand_grant[%0d]: got %0d want %0d", it, q, q_exp); end
            tests_run++; if (st !== 1'b1) begin tests_failed++; $display("FAIL rand_stable[%0d]: got %b want 1", it, st); end
            tests_run++; if (n_buf - b0 !== 1 || n_occ - o0 !== 1) begin tests_failed++; $display("FAIL rand_strobes[%0d]: got %0d/%0d want 1/1", it, n_buf - b0, n_occ - o0); end
            tests_run++; if (last_addr !== int'(pg) * WPP + int'(wd)) begin tests_failed++; $display("FAIL rand_addr[%0d]: got %0h want %0h", it, last_addr, int'(pg) * WPP + int'(wd)); end
            tests_run++; if (last_bq !== q_exp || last_tuser !== q_exp || last_tdata !== BPW) begin tests_failed++; $display("FAIL rand_occ[%0d]: got q%0d u%0d d%0d want %0d/%0d/%0d", it, last_bq, last_tuser, last_tdata, q_exp, q_exp, BPW); end
            rr_m = q_exp;
            if (q_exp >= 0 && words[q_exp] > 0) words[q_exp]--;
        end
        queue_empty = '1; egr_ready = '1;
        @(negedge clk);
        tests_run++; if (n_pair_err !== 0) begin tests_failed++; $display("FAIL strobe_pairing: got %0d mismatched cycles want 0", n_pair_err); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_egr_gating();
        test_arready_stall();
        test_timeout();
        test_reset_in_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
